// File: rtl/memory_ctrl_pkg.sv
`default_nettype none
// ==================================================================
// memory_ctrl_pkg: shared widths, opcodes and states for the
// memory access controller.                          Revision: 1.0
// ==================================================================
package memory_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 3;
    localparam int WORDS  = 32;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_BURST = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/read_tracker.sv
`default_nettype none
// ==================================================================
// read_tracker: follows issued read beats through the memory latency
// and registers the tagged response.                 Revision: 1.0
// ==================================================================
module read_tracker
    import memory_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] mem_dataOut,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              outstanding
);

    logic [READ_LATENCY-1:0] r_pipe_valid;
    logic [ADDR_W-1:0]       r_pipe_addr [READ_LATENCY];

    // Stage READ_LATENCY-1 is valid exactly in the cycle the memory word is on mem_dataOut.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pipe_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pipe_addr[k] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
        end else begin
            r_pipe_valid[0] <= issue;
            r_pipe_addr[0]  <= issue_addr;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_valid[k] <= r_pipe_valid[k-1];
                r_pipe_addr[k]  <= r_pipe_addr[k-1];
            end
            rsp_valid <= r_pipe_valid[READ_LATENCY-1];
            if (r_pipe_valid[READ_LATENCY-1]) begin
                rsp_addr <= r_pipe_addr[READ_LATENCY-1];
                rsp_data <= mem_dataOut;
            end
        end
    end

    assign outstanding = |r_pipe_valid;

endmodule
`default_nettype wire

// File: rtl/memory_access_controller.sv
`default_nettype none
// ==================================================================
// memory_access_controller: sequences write / read / burst / clear
// commands onto a 32-word x 32-bit memory.           Revision: 1.0
// ==================================================================
module memory_access_controller
    import memory_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              busy,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_rE,
    output logic              mem_wE,
    input  logic [DATA_W-1:0] mem_dataOut
);

    state_e            r_state;
    state_e            w_state_next;
    logic [LEN_W-1:0]  r_beats_left;
    logic [LEN_W-1:0]  w_beats_left_next;
    logic [DATA_W-1:0] w_mem_data_next;
    logic [ADDR_W-1:0] w_mem_address_next;
    logic              w_mem_rE_next;
    logic              w_mem_wE_next;
    logic              w_outstanding;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_beats_left <= '0;
            mem_data     <= '0;
            mem_address  <= '0;
            mem_rE       <= 1'b0;
            mem_wE       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_beats_left <= w_beats_left_next;
            mem_data     <= w_mem_data_next;
            mem_address  <= w_mem_address_next;
            mem_rE       <= w_mem_rE_next;
            mem_wE       <= w_mem_wE_next;
        end
    end

    // Strobes are computed one cycle ahead so every memory-side output is a flop.
    always_comb begin
        w_state_next       = r_state;
        w_beats_left_next  = r_beats_left;
        w_mem_data_next    = mem_data;
        w_mem_address_next = mem_address;
        w_mem_rE_next      = 1'b0;
        w_mem_wE_next      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (op_e'(cmd_op))
                        OP_WRITE: begin
                            w_state_next       = ST_WRITE;
                            w_mem_wE_next      = 1'b1;
                            w_mem_address_next = cmd_addr;
                            w_mem_data_next    = cmd_data;
                        end
                        OP_READ: begin
                            w_state_next       = ST_READ;
                            w_mem_rE_next      = 1'b1;
                            w_mem_address_next = cmd_addr;
                            w_beats_left_next  = '0;
                        end
                        OP_BURST: begin
                            w_state_next       = ST_READ;
                            w_mem_rE_next      = 1'b1;
                            w_mem_address_next = cmd_addr;
                            w_beats_left_next  = cmd_len;
                        end
                        OP_CLEAR: begin
                            w_state_next       = ST_CLEAR;
                            w_mem_wE_next      = 1'b1;
                            w_mem_address_next = '0;
                            w_mem_data_next    = '0;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                w_state_next = ST_IDLE;
            end
            ST_READ: begin
                if (r_beats_left == '0) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_mem_rE_next      = 1'b1;
                    w_mem_address_next = mem_address + 1'b1;
                    w_beats_left_next  = r_beats_left - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!w_outstanding) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (mem_address == LAST_ADDR) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_mem_wE_next      = 1'b1;
                    w_mem_address_next = mem_address + 1'b1;
                    w_mem_data_next    = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    read_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_read_tracker (
        .clock       (clock),
        .reset       (reset),
        .issue       (mem_rE),
        .issue_addr  (mem_address),
        .mem_dataOut (mem_dataOut),
        .rsp_valid   (rsp_valid),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data),
        .outstanding (w_outstanding)
    );

endmodule
`default_nettype wire

// File: tb/tb_memory_access_controller.sv
`default_nettype none
// ==================================================================
// tb_memory_access_controller: scoreboard bench, two instances with
// read latency 1 and 3 against a word-array reference.  Revision: 1.0
// ==================================================================
module tb_memory_access_controller;

    localparam int NDUT = 2;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } strobe_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } rsp_t;

    logic clock = 1'b0;
    logic reset;
    logic mem_init;
    always #5 clock = ~clock;

    logic        cmd_valid   [NDUT];
    logic        cmd_ready   [NDUT];
    logic [1:0]  cmd_op      [NDUT];
    logic [4:0]  cmd_addr    [NDUT];
    logic [2:0]  cmd_len     [NDUT];
    logic [31:0] cmd_data    [NDUT];
    logic        rsp_valid   [NDUT];
    logic [31:0] rsp_data    [NDUT];
    logic [4:0]  rsp_addr    [NDUT];
    logic        busy        [NDUT];
    logic [31:0] mem_data    [NDUT];
    logic [4:0]  mem_address [NDUT];
    logic        mem_rE      [NDUT];
    logic        mem_wE      [NDUT];
    logic [31:0] mem_dataOut [NDUT];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    strobe_t     sq      [NDUT][$];
    rsp_t        rq      [NDUT][$];
    logic [31:0] ref_mem [NDUT][32];

    function automatic logic [31:0] init_word(input int d, input int i);
        return {8'hA5 ^ 8'(d), 8'(i), 16'(i * 40503 + 7)};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle=%0d actual=%h required=%h", name, d, cyc, act, exp);
        end
    endtask

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        localparam int LAT = (d == 0) ? 1 : 3;
        logic [31:0] ram     [32];
        logic [31:0] rd_pipe [LAT];

        memory_access_controller #(.READ_LATENCY(LAT)) u_dut (
            .clock       (clock),
            .reset       (reset),
            .cmd_valid   (cmd_valid[d]),
            .cmd_ready   (cmd_ready[d]),
            .cmd_op      (cmd_op[d]),
            .cmd_addr    (cmd_addr[d]),
            .cmd_len     (cmd_len[d]),
            .cmd_data    (cmd_data[d]),
            .rsp_valid   (rsp_valid[d]),
            .rsp_data    (rsp_data[d]),
            .rsp_addr    (rsp_addr[d]),
            .busy        (busy[d]),
            .mem_data    (mem_data[d]),
            .mem_address (mem_address[d]),
            .mem_rE      (mem_rE[d]),
            .mem_wE      (mem_wE[d]),
            .mem_dataOut (mem_dataOut[d])
        );

        // Behavioural memory: word available LAT cycles after the rE cycle.
        always @(posedge clock) begin
            if (mem_init) begin
                for (int i = 0; i < 32; i++) ram[i] <= init_word(d, i);
            end else if (mem_wE[d]) begin
                ram[mem_address[d]] <= mem_data[d];
            end
            if (mem_rE[d]) rd_pipe[0] <= ram[mem_address[d]];
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign mem_dataOut[d] = rd_pipe[LAT-1];
    end

    // Monitor: every strobe / response the DUT shows is popped from the scoreboard.
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            for (int d = 0; d < NDUT; d++) begin
                strobe_t s;
                rsp_t    r;
                chk("busy_vs_ready", d, {31'b0, busy[d] ^ cmd_ready[d]}, 32'd1);
                if (mem_rE[d] === 1'b1 || mem_wE[d] === 1'b1) begin
                    chk("strobe_exclusive", d, {31'b0, mem_rE[d] & mem_wE[d]}, 32'd0);
                    chk("strobe_expected", d, {31'b0, sq[d].size() != 0}, 32'd1);
                    if (sq[d].size() != 0) begin
                        s = sq[d].pop_front();
                        chk("strobe_cycle", d, cyc, s.cyc);
                        chk("strobe_kind_we", d, {31'b0, mem_wE[d]}, {31'b0, s.we});
                        chk("strobe_addr", d, {27'b0, mem_address[d]}, {27'b0, s.addr});
                        if (s.we) chk("strobe_data", d, mem_data[d], s.data);
                    end
                end
                if (rsp_valid[d] === 1'b1) begin
                    chk("rsp_expected", d, {31'b0, rq[d].size() != 0}, 32'd1);
                    if (rq[d].size() != 0) begin
                        r = rq[d].pop_front();
                        chk("rsp_cycle", d, cyc, r.cyc);
                        chk("rsp_addr", d, {27'b0, rsp_addr[d]}, {27'b0, r.addr});
                        chk("rsp_data", d, rsp_data[d], r.data);
                    end
                end
            end
        end
    end

    // Drives one command at a negedge and records its expected strobes/responses.
    task automatic issue_start(input int d, input logic [1:0] op, input logic [4:0] addr,
                               input logic [2:0] len, input logic [31:0] data, output int t_ready);
        int n;
        int a;
        int nb;
        logic [4:0] ad;
        strobe_t s;
        rsp_t r;
        n = 0;
        while (cmd_ready[d] !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_issue", d, {31'b0, cmd_ready[d]}, 32'd1);
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_addr[d]  = addr;
        cmd_len[d]   = len;
        cmd_data[d]  = data;
        a = cyc;
        t_ready = a + 2;
        case (op)
            2'b00: begin
                s = '{we: 1'b1, addr: addr, data: data, cyc: 32'(a + 1)};
                sq[d].push_back(s);
                ref_mem[d][addr] = data;
            end
            2'b01, 2'b10: begin
                nb = (op == 2'b01) ? 1 : int'(len) + 1;
                for (int i = 0; i < nb; i++) begin
                    ad = addr + 5'(i);
                    s = '{we: 1'b0, addr: ad, data: 32'd0, cyc: 32'(a + 1 + i)};
                    sq[d].push_back(s);
                    r = '{addr: ad, data: ref_mem[d][ad], cyc: 32'(a + 1 + i + lat_of(d) + 1)};
                    rq[d].push_back(r);
                end
                t_ready = a + nb + lat_of(d) + 2;
            end
            default: begin
                for (int i = 0; i < 32; i++) begin
                    s = '{we: 1'b1, addr: 5'(i), data: 32'd0, cyc: 32'(a + 1 + i)};
                    sq[d].push_back(s);
                    ref_mem[d][i] = 32'd0;
                end
                t_ready = a + 33;
            end
        endcase
        @(negedge clock);
    endtask

    // Waits for the command to complete; with hold, keeps offering junk commands while busy.
    task automatic issue_finish(input int d, input int t_ready, input bit hold);
        int n;
        n = 0;
        while (cmd_ready[d] !== 1'b1 && n < 300) begin
            cmd_valid[d] = hold;
            if (hold) begin
                cmd_op[d]   = 2'($urandom);
                cmd_addr[d] = 5'($urandom);
                cmd_len[d]  = 3'($urandom);
                cmd_data[d] = $urandom;
            end
            @(negedge clock);
            n++;
        end
        cmd_valid[d] = 1'b0;
        chk("ready_return_cycle", d, cyc, t_ready);
        chk("strobes_all_seen", d, sq[d].size(), 32'd0);
        chk("rsps_all_seen", d, rq[d].size(), 32'd0);
    endtask

    task automatic run(input int d, input logic [1:0] op, input logic [4:0] addr,
                       input logic [2:0] len, input logic [31:0] data, input bit hold);
        int t;
        issue_start(d, op, addr, len, data, t);
        issue_finish(d, t, hold);
    endtask

    initial begin
        int t;
        int n;
        int quiet;
        int d;
        int sel;
        logic [1:0] op;
        reset    = 1'b1;
        mem_init = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_op[k]    = 2'b00;
            cmd_addr[k]  = 5'd0;
            cmd_len[k]   = 3'd0;
            cmd_data[k]  = 32'd0;
            for (int i = 0; i < 32; i++) ref_mem[k][i] = init_word(k, i);
        end
        repeat (3) @(negedge clock);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("reset_busy", k, {31'b0, busy[k]}, 32'd0);
            chk("reset_rsp_valid", k, {31'b0, rsp_valid[k]}, 32'd0);
            chk("reset_rsp_data", k, rsp_data[k], 32'd0);
            chk("reset_rsp_addr", k, {27'b0, rsp_addr[k]}, 32'd0);
            chk("reset_mem_data", k, mem_data[k], 32'd0);
            chk("reset_mem_address", k, {27'b0, mem_address[k]}, 32'd0);
            chk("reset_mem_strobes", k, {30'b0, mem_rE[k], mem_wE[k]}, 32'd0);
        end
        mem_init = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < NDUT; k++) chk("ready_after_reset", k, {31'b0, cmd_ready[k]}, 32'd1);

        // Write then read back, burst with wrap, on both latencies.
        run(0, 2'b00, 5'd5, 3'd0, 32'hDEADBEEF, 1'b0);
        run(0, 2'b01, 5'd5, 3'd0, 32'd0, 1'b0);
        run(0, 2'b10, 5'd30, 3'd3, 32'd0, 1'b0);
        run(1, 2'b00, 5'd31, 3'd0, 32'h0BADF00D, 1'b0);
        run(1, 2'b10, 5'd30, 3'd3, 32'd0, 1'b0);

        // Clear after scattered writes, then sweep all 32 words.
        run(0, 2'b00, 5'd0, 3'd0, 32'h11111111, 1'b0);
        run(0, 2'b00, 5'd17, 3'd0, 32'h22222222, 1'b0);
        run(0, 2'b00, 5'd31, 3'd0, 32'h33333333, 1'b0);
        run(0, 2'b11, 5'd9, 3'd0, 32'hFFFFFFFF, 1'b0);
        for (int b = 0; b < 4; b++) run(0, 2'b10, 5'(b * 8), 3'd7, 32'd0, 1'b0);

        // Commands offered while busy must be ignored; next one lands right at ready.
        run(0, 2'b00, 5'd12, 3'd0, 32'hCAFEF00D, 1'b0);
        run(0, 2'b10, 5'd10, 3'd5, 32'd0, 1'b1);
        run(0, 2'b01, 5'd12, 3'd0, 32'd0, 1'b1);
        run(1, 2'b10, 5'd28, 3'd7, 32'd0, 1'b1);

        for (int k = 0; k < 60; k++) begin
            d   = (k % 3 == 2) ? 1 : 0;
            sel = $urandom_range(0, 7);
            op  = (sel < 3) ? 2'b00 : (sel < 5) ? 2'b01 : (sel < 7) ? 2'b10 : 2'b11;
            run(d, op, 5'($urandom), 3'($urandom), $urandom, 1'($urandom));
        end

        // Asynchronous reset in the middle of an 8-beat burst.
        issue_start(0, 2'b10, 5'd20, 3'd7, 32'd0, t);
        cmd_valid[0] = 1'b0;
        #1;
        n = 0;
        while (rq[0].size() > 5 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("three_rsps_before_reset", 0, rq[0].size(), 32'd5);
        #1 reset = 1'b1;
        #1;
        chk("midreset_mem_rE", 0, {31'b0, mem_rE[0]}, 32'd0);
        chk("midreset_rsp_valid", 0, {31'b0, rsp_valid[0]}, 32'd0);
        chk("midreset_busy", 0, {31'b0, busy[0]}, 32'd0);
        chk("midreset_mem_address", 0, {27'b0, mem_address[0]}, 32'd0);
        chk("midreset_rsp_data", 0, rsp_data[0], 32'd0);
        chk("midreset_rsp_addr", 0, {27'b0, rsp_addr[0]}, 32'd0);
        sq[0].delete();
        rq[0].delete();
        @(negedge clock);
        #2 reset = 1'b0;
        quiet = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (rsp_valid[0] === 1'b1) quiet++;
        end
        chk("no_rsp_after_reset", 0, quiet, 32'd0);
        chk("ready_after_midreset", 0, {31'b0, cmd_ready[0]}, 32'd1);
        run(0, 2'b01, 5'd17, 3'd0, 32'd0, 1'b0);
        run(0, 2'b10, 5'd3, 3'd2, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog dut0 cycle=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
